sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Two-master arbiter that shares the single az_/za_ port of sram_controller between master 0 (CPU) and master 1 (DMA/video).
- Grants one master at a time, round-robin after every accepted transfer.
- Records the issuing master of every accepted read in an in-order tag FIFO, and routes each za_valid/za_data return to that master.
- Sits between the system masters and sram_controller; requires no change to sram_controller.

Parameters:
- RD_DEPTH, 4, maximum outstanding reads (tag FIFO depth; power of 2, 2..16).
- ADDR_W, 22, request address width.
- DATA_W, 16, data width.

Ports:
- clk  in  1  system clock (100–143 MHz).
- reset_n  in  1  asynchronous active-low reset.
- m0_cs, m1_cs  in  1 each  request strobe.
- m0_rd_n, m1_rd_n  in  1 each  read op, active low.
- m0_wr_n, m1_wr_n  in  1 each  write op, active low.
- m0_be_n, m1_be_n  in  2 each  byte-enable mask, active low.
- m0_addr, m1_addr  in  ADDR_W each  request address.
- m0_data, m1_data  in  DATA_W each  write data.
- m0_wait, m1_wait  out  1 each  stall; the request is held while this is high.
- m0_valid, m1_valid  out  1 each  read data valid for this master.
- m_rdata  out  DATA_W  read data, broadcast to both masters (equals za_data).
- az_cs, az_rd_n, az_wr_n, az_be_n, az_addr, az_data  out  to sram_controller.
- za_wait  in  1  controller busy.
- za_valid  in  1  controller read data valid.
- za_data  in  DATA_W  controller read data.
- rd_orphan  out  1  sticky: za_valid arrived with tag FIFO empty.

Behaviour:
- Clocking/reset: one clock domain (clk); reset asynchronous, active low (reset_n).
- Reset values:
  - state = ARB_IDLE, tag FIFO empty, rd_orphan = 0, round-robin pointer = master 0.
  - Hence az_cs = 0, az_rd_n = 1, az_wr_n = 1, az_be_n = 2'b11, az_addr = 0, az_data = 0.
  - m0_wait = m1_wait = 1, m0_valid = m1_valid = 0.
- Reset mid-operation: outstanding tags are discarded; later za_valid pulses are handled as orphans.
- FSM states: ARB_IDLE, ARB_M0, ARB_M1 (registered).
  - ARB_IDLE: az_* driven to their reset values.
    - Only one cs high: go to that master's state.
    - Both high: go to the master named by the round-robin pointer.
  - ARB_Mn: az_* = master n's signals, combinational mux.
    - Accept = az_cs & ~za_wait at the rising edge.
    - On accept: pointer <= other master. Next state = other master's state if its cs is high; else stay if mn_cs is high; else ARB_IDLE.
    - No accept and mn_cs low: go to the other master's state if its cs is high, else ARB_IDLE.
- Qualification:
  - az_cs = mn_cs & ~(rd_req & fifo_full), where rd_req = ~mn_rd_n.
  - Writes are never blocked by a full FIFO.
- Wait outputs:
  - mn_wait = ~(state == ARB_Mn & az_cs & ~za_wait).
  - The ungranted master always sees wait = 1.
  - Minimum arbitration latency from ARB_IDLE: 1 cycle of wait.
- Tag FIFO:
  - Push master id (0/1) on an accepted read.
  - Pop on za_valid when not empty.
  - Push and pop in the same cycle: count unchanged; works when full or empty.
  - Pointers wrap modulo RD_DEPTH; count width is clog2(RD_DEPTH)+1.
- Return routing:
  - mn_valid = za_valid & ~fifo_empty & (head == n), combinational.
  - m_rdata = za_data.
  - za_valid with FIFO empty: no mn_valid; rd_orphan set until reset.
- Illegal request (rd_n and wr_n both low, or both high, with cs high): forwarded unchanged; no tag is pushed unless rd_n is low.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- Defined: master 0 always wins simultaneous requests, and master 0 pre-empts on every accept boundary. The round-robin pointer is not implemented.
- Undefined: round-robin exactly as specified in Behaviour.

Decomposition:
- Package sram_arb_pkg: state encoding (ARB_IDLE = 2'd0, ARB_M0 = 2'd1, ARB_M1 = 2'd2), master-id type (1 bit), constant BE_NONE = 2'b11.
- Sub-module sram_arb_tag_fifo:
  - parameterised by RD_DEPTH;
  - ports: clk, reset_n, push, push_id, pop, head_id, full, empty.

Test Plan:
1. Reset with both cs high, release reset → first cycle m0_wait = m1_wait = 1, az_cs = 0; next cycle grant = M0, az_addr = m0_addr.
2. Both masters stream writes (m0_addr = 0x000010, m1_addr = 0x200020), za_wait = 0 → accepts alternate M0, M1, M0, M1; each master's wait toggles every cycle.
3. m1 issues 4 reads while za_valid is held low (RD_DEPTH = 4) → 5th m1 read gets m1_wait = 1, az_cs = 0. A concurrent m0 write is still accepted. One za_valid pulse → m1_valid = 1 and the 5th read is accepted the next cycle.
4. Reads issued in the order M0, M1, M0; three za_valid pulses with za_data = 0xAAAA, 0xBBBB, 0xCCCC → valid pulses on m0, m1, m0 in that order with matching m_rdata.
5. za_valid pulse with no outstanding reads → m0_valid = m1_valid = 0, rd_orphan = 1 and stays 1. Assert reset_n low mid-stream → all outputs return to reset values asynchronously.
6. SRAM_ARB_FIXED_PRIO_EN defined, both masters streaming → all accepts go to M0; M1 is accepted only once m0_cs drops.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM arbiter.
// Holds the FSM state encoding and the master-id type.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_M0   = 2'd1,
    ARB_M1   = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

  localparam logic [1:0] BE_NONE = 2'b11;

endpackage

// File: rtl/sram_arb_tag_fifo.sv
// In-order tag FIFO recording which master issued each outstanding read.
// RD_DEPTH must be a power of two so the pointers wrap naturally.
module sram_arb_tag_fifo
  import sram_arb_pkg::*;
#(
  parameter int RD_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  master_id_t push_id,
  input  logic       pop,
  output master_id_t head_id,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(RD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  master_id_t       mem [RD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_en;
  logic             pop_en;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(RD_DEPTH));
  assign pop_en  = pop & ~empty;
  // A simultaneous pop frees the slot, so a push while full is still legal.
  assign push_en = push & (~full | pop_en);
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of sram_controller with in-order read return routing.
// Define SRAM_ARB_FIXED_PRIO_EN to give master 0 fixed priority instead of round-robin.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ARB_IDLE | no grant; az_* held at idle values
//   ARB_M0   | master 0 drives az_*
//   ARB_M1   | master 1 drives az_*
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int RD_DEPTH = 4,
  parameter int ADDR_W   = 22,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_cs,
  input  logic              m0_rd_n,
  input  logic              m0_wr_n,
  input  logic [1:0]        m0_be_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data,
  input  logic              m1_cs,
  input  logic              m1_rd_n,
  input  logic              m1_wr_n,
  input  logic [1:0]        m1_be_n,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data,
  output logic              m0_wait,
  output logic              m1_wait,
  output logic              m0_valid,
  output logic              m1_valid,
  output logic [DATA_W-1:0] m_rdata,
  output logic              az_cs,
  output logic              az_rd_n,
  output logic              az_wr_n,
  output logic [1:0]        az_be_n,
  output logic [ADDR_W-1:0] az_addr,
  output logic [DATA_W-1:0] az_data,
  input  logic              za_wait,
  input  logic              za_valid,
  input  logic [DATA_W-1:0] za_data,
  output logic              rd_orphan
);

  arb_state_t state;
  arb_state_t state_nxt;
  arb_state_t tie_state;
  logic       sel_cs;
  logic       rd_req;
  logic       accept;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  master_id_t head_id;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign tie_state = ARB_M0;
`else
  master_id_t rr_ptr;
  master_id_t rr_ptr_nxt;
  assign tie_state = rr_ptr ? ARB_M1 : ARB_M0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB_IDLE;
      rd_orphan <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      rd_orphan <= rd_orphan | (za_valid & fifo_empty);
`ifndef SRAM_ARB_FIXED_PRIO_EN
      rr_ptr    <= rr_ptr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    rr_ptr_nxt = rr_ptr;
`endif
    case (state)
      ARB_IDLE: begin
        if (m0_cs && m1_cs) state_nxt = tie_state;
        else if (m0_cs)     state_nxt = ARB_M0;
        else if (m1_cs)     state_nxt = ARB_M1;
      end
      ARB_M0: begin
        if (accept) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
          if (m0_cs)      state_nxt = ARB_M0;
          else if (m1_cs) state_nxt = ARB_M1;
          else            state_nxt = ARB_IDLE;
`else
          rr_ptr_nxt = 1'b1;
          if (m1_cs)      state_nxt = ARB_M1;
          else if (m0_cs) state_nxt = ARB_M0;
          else            state_nxt = ARB_IDLE;
`endif
        end else if (!m0_cs) begin
          state_nxt = m1_cs ? ARB_M1 : ARB_IDLE;
        end
      end
      ARB_M1: begin
        // Master 0 is preferred after an M1 accept in both priority modes.
        if (accept) begin
`ifndef SRAM_ARB_FIXED_PRIO_EN
          rr_ptr_nxt = 1'b0;
`endif
          if (m0_cs)      state_nxt = ARB_M0;
          else if (m1_cs) state_nxt = ARB_M1;
          else            state_nxt = ARB_IDLE;
        end else if (!m1_cs) begin
          state_nxt = m0_cs ? ARB_M0 : ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    sel_cs  = 1'b0;
    az_rd_n = 1'b1;
    az_wr_n = 1'b1;
    az_be_n = BE_NONE;
    az_addr = '0;
    az_data = '0;
    case (state)
      ARB_M0: begin
        sel_cs  = m0_cs;
        az_rd_n = m0_rd_n;
        az_wr_n = m0_wr_n;
        az_be_n = m0_be_n;
        az_addr = m0_addr;
        az_data = m0_data;
      end
      ARB_M1: begin
        sel_cs  = m1_cs;
        az_rd_n = m1_rd_n;
        az_wr_n = m1_wr_n;
        az_be_n = m1_be_n;
        az_addr = m1_addr;
        az_data = m1_data;
      end
      default: ;
    endcase
    // Reads stall on a full tag FIFO; writes need no tag and pass through.
    rd_req   = ~az_rd_n;
    az_cs    = sel_cs & ~(rd_req & fifo_full);
    accept   = az_cs & ~za_wait;
    m0_wait  = ~((state == ARB_M0) & accept);
    m1_wait  = ~((state == ARB_M1) & accept);
    fifo_pop = za_valid & ~fifo_empty;
    m0_valid = fifo_pop & (head_id == 1'b0);
    m1_valid = fifo_pop & (head_id == 1'b1);
    m_rdata  = za_data;
  end

  sram_arb_tag_fifo #(
    .RD_DEPTH (RD_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept & rd_req),
    .push_id (state == ARB_M1),
    .pop     (fifo_pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level model (owner, pointer, tag queue).
module tb_sram_arbiter;

  localparam int RD_DEPTH = 4;
  localparam int ADDR_W   = 22;
  localparam int DATA_W   = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              cs   [2];
  logic              rd_n [2];
  logic              wr_n [2];
  logic [1:0]        be_n [2];
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] wdat [2];
  logic              za_wait, za_valid;
  logic [DATA_W-1:0] za_data;

  logic              m0_wait, m1_wait, m0_valid, m1_valid;
  logic [DATA_W-1:0] m_rdata;
  logic              az_cs, az_rd_n, az_wr_n;
  logic [1:0]        az_be_n;
  logic [ADDR_W-1:0] az_addr;
  logic [DATA_W-1:0] az_data;
  logic              rd_orphan;

  sram_arbiter #(.RD_DEPTH(RD_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_cs(cs[0]), .m0_rd_n(rd_n[0]), .m0_wr_n(wr_n[0]), .m0_be_n(be_n[0]),
    .m0_addr(addr[0]), .m0_data(wdat[0]),
    .m1_cs(cs[1]), .m1_rd_n(rd_n[1]), .m1_wr_n(wr_n[1]), .m1_be_n(be_n[1]),
    .m1_addr(addr[1]), .m1_data(wdat[1]),
    .m0_wait(m0_wait), .m1_wait(m1_wait), .m0_valid(m0_valid), .m1_valid(m1_valid),
    .m_rdata(m_rdata),
    .az_cs(az_cs), .az_rd_n(az_rd_n), .az_wr_n(az_wr_n), .az_be_n(az_be_n),
    .az_addr(az_addr), .az_data(az_data),
    .za_wait(za_wait), .za_valid(za_valid), .za_data(za_data),
    .rd_orphan(rd_orphan)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 none), round-robin preference, outstanding tags.
  int own;
  int pref;
  int tags[$];
  bit orph;
  bit acc [2];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit granted_cs();
    if (own < 0) return 1'b0;
    return cs[own] && !(!rd_n[own] && tags.size() >= RD_DEPTH);
  endfunction

  task automatic model_reset();
    own = -1; pref = 0; tags.delete(); orph = 0; acc[0] = 0; acc[1] = 0;
  endtask

  task automatic cmp_now();
    bit gc;
    int head;
    bit hv;
    logic [42:0] e_az;
    gc   = granted_cs();
    head = (tags.size() > 0) ? tags[0] : -1;
    hv   = za_valid && (tags.size() > 0);
    if (own < 0) e_az = {1'b0, 1'b1, 1'b1, 2'b11, {ADDR_W{1'b0}}, {DATA_W{1'b0}}};
    else         e_az = {gc, rd_n[own], wr_n[own], be_n[own], addr[own], wdat[own]};
    check("az_bus", 64'({az_cs, az_rd_n, az_wr_n, az_be_n, az_addr, az_data}), 64'(e_az));
    check("wait", 64'({m1_wait, m0_wait}),
          64'({!(own == 1 && gc && !za_wait), !(own == 0 && gc && !za_wait)}));
    check("valid", 64'({m1_valid, m0_valid}), 64'({hv && head == 1, hv && head == 0}));
    check("rdata", 64'(m_rdata), 64'(za_data));
    check("orphan", 64'(rd_orphan), 64'(orph));
  endtask

  task automatic model_update();
    bit a;
    bit rdp;
    int o;
    a   = granted_cs() && !za_wait;
    o   = own;
    rdp = (o >= 0) && !rd_n[o];
    acc[0] = a && o == 0;
    acc[1] = a && o == 1;
    if (za_valid) begin
      if (tags.size() > 0) void'(tags.pop_front());
      else orph = 1;
    end
    if (a && rdp) tags.push_back(o);
    if (o < 0) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      if (cs[0] && cs[1]) own = 0;
`else
      if (cs[0] && cs[1]) own = pref;
`endif
      else if (cs[0]) own = 0;
      else if (cs[1]) own = 1;
    end else if (a) begin
      pref = 1 - o;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      own = cs[0] ? 0 : (cs[1] ? 1 : -1);
`else
      own = cs[1-o] ? 1 - o : (cs[o] ? o : -1);
`endif
    end else if (!cs[o]) begin
      own = cs[1-o] ? 1 - o : -1;
    end
  endtask

  task automatic half();
    @(negedge clk);
    cmp_now();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    half();
    tick();
  endtask

  task automatic set_req(int n, bit c, bit r_n, bit w_n, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    cs[n] = c; rd_n[n] = r_n; wr_n[n] = w_n; be_n[n] = 2'b00; addr[n] = a; wdat[n] = d;
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) set_req(n, 0, 1, 1, '0, '0);
    za_wait = 0; za_valid = 0; za_data = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    #12;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  task automatic issue_read(int n, logic [ADDR_W-1:0] a);
    bit got;
    got = 0;
    set_req(n, 1, 0, 1, a, '0);
    for (int k = 0; k < 10 && !got; k++) begin
      half();
      got = ((n == 1) ? m1_wait : m0_wait) === 1'b0;
      tick();
    end
    check("issue_grant", 64'(got), 64'(1));
    cs[n] = 0;
  endtask

  initial begin
    int n0, n1;
    logic [DATA_W-1:0] rdv [3];
    int               rdm [3];
    rdv[0] = 16'hAAAA; rdv[1] = 16'hBBBB; rdv[2] = 16'hCCCC;
    rdm[0] = 0; rdm[1] = 1; rdm[2] = 0;

    // Reset with both masters requesting writes, then streaming writes.
    idle_inputs();
    set_req(0, 1, 1, 0, 22'h000010, 16'h1111);
    set_req(1, 1, 1, 0, 22'h200020, 16'h2222);
    do_reset();
    half();
    check("rst_wait", 64'({m1_wait, m0_wait}), 64'(2'b11));
    check("rst_az_cs", 64'(az_cs), 64'(0));
    tick();
    for (int i = 0; i < 6; i++) begin
      int em;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      em = 0;
`else
      em = i % 2;
`endif
      half();
      check("stream_addr", 64'(az_addr), 64'((em == 1) ? 22'h200020 : 22'h000010));
      check("stream_wait", 64'({m1_wait, m0_wait}), 64'((em == 1) ? 2'b01 : 2'b10));
      tick();
    end
    cs[0] = 0;
    cycle();
    half();
    check("m1_after_m0_drop", 64'({az_cs, az_addr, m1_wait}), 64'({1'b1, 22'h200020, 1'b0}));
    tick();

    // Tag FIFO fills with m1 reads while m0 writes keep flowing.
    idle_inputs();
    do_reset();
    set_req(0, 1, 1, 0, 22'h000100, 16'h5A5A);
    set_req(1, 1, 0, 1, 22'h000300, 16'h0000);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      half();
      if (m0_wait === 1'b0) n0++;
      if (m1_wait === 1'b0) n1++;
      tick();
    end
`ifndef SRAM_ARB_FIXED_PRIO_EN
    check("full_m0_accepts", 64'(n0), 64'(5));
    check("full_m1_accepts", 64'(n1), 64'(4));
    half();
    check("full_block", 64'({az_cs, m1_wait}), 64'({1'b0, 1'b1}));
    tick();
    za_valid = 1; za_data = 16'h1234;
    half();
    check("full_pop_valid", 64'({m1_valid, m0_valid}), 64'(2'b10));
    tick();
    za_valid = 0;
    half();
    check("fifth_read", 64'({az_cs, m1_wait}), 64'({1'b1, 1'b0}));
    tick();
`endif

    // Return routing follows issue order.
    idle_inputs();
    do_reset();
    issue_read(0, 22'h000A00);
    issue_read(1, 22'h000B00);
    issue_read(0, 22'h000C00);
    cycle();
    for (int k = 0; k < 3; k++) begin
      za_valid = 1; za_data = rdv[k];
      half();
      check("route_valid", 64'({m1_valid, m0_valid}), 64'((rdm[k] == 1) ? 2'b10 : 2'b01));
      check("route_data", 64'(m_rdata), 64'(rdv[k]));
      tick();
    end
    za_valid = 0;
    cycle();

    // Orphan return, then asynchronous reset in the middle of traffic.
    idle_inputs();
    do_reset();
    za_valid = 1; za_data = 16'hDEAD;
    half();
    check("orphan_no_valid", 64'({m1_valid, m0_valid}), 64'(2'b00));
    tick();
    za_valid = 0;
    for (int i = 0; i < 3; i++) begin
      half();
      check("orphan_sticky", 64'(rd_orphan), 64'(1));
      tick();
    end
    set_req(0, 1, 0, 1, 22'h0000F0, 16'h0);
    set_req(1, 1, 1, 0, 22'h3FFFFF, 16'hFFFF);
    for (int i = 0; i < 3; i++) cycle();
    #2;
    reset_n = 0;
    #1;
    check("arst_az", 64'({az_cs, az_rd_n, az_wr_n, az_be_n, az_addr, az_data}),
          64'({1'b0, 1'b1, 1'b1, 2'b11, {ADDR_W{1'b0}}, {DATA_W{1'b0}}}));
    check("arst_wait_valid", 64'({m1_wait, m0_wait, m1_valid, m0_valid}), 64'(4'b1100));
    check("arst_orphan", 64'(rd_orphan), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;

    // Randomized traffic against the model.
    idle_inputs();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!(cs[n] && !acc[n] && $urandom_range(7) != 0)) begin
          int op;
          op = $urandom_range(9);
          cs[n]   = ($urandom_range(3) != 0);
          if (op < 5)      begin rd_n[n] = 0; wr_n[n] = 1; end
          else if (op < 9) begin rd_n[n] = 1; wr_n[n] = 0; end
          else begin
            rd_n[n] = $urandom_range(1) != 0;
            wr_n[n] = rd_n[n];
          end
          be_n[n] = 2'($urandom_range(3));
          addr[n] = ADDR_W'($urandom);
          wdat[n] = DATA_W'($urandom);
        end
      end
      za_wait  = ($urandom_range(3) == 0);
      za_valid = (tags.size() > 0) && ($urandom_range(2) == 0);
      za_data  = DATA_W'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
